reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Write-port arbiter and scoreboard for the 8x8 CPU register file, which has a single write port.
- Shares that port between two writeback sources, the ALU and the data-memory load path, using round-robin priority.
- Keeps a per-register pending-write scoreboard so the instruction decoder can stall on read-after-write hazards.
- Sits between decode/execute/memory stages and the register file's IN/INADDRESS/WRITE inputs.

Parameters:
DATA_WIDTH, 8, register data width
ADDR_WIDTH, 3, register address width; NUM_REGS = 2**ADDR_WIDTH
CNT_WIDTH, 2, width of per-register pending-write counter

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
ALU_REQ  input  1  ALU writeback request; held until ALU_GNT
ALU_ADDR  input  ADDR_WIDTH  ALU destination register
ALU_DATA  input  DATA_WIDTH  ALU result
ALU_GNT  output  1  combinational grant to ALU
MEM_REQ  input  1  load writeback request; held until MEM_GNT
MEM_ADDR  input  ADDR_WIDTH  load destination register
MEM_DATA  input  DATA_WIDTH  loaded data
MEM_GNT  output  1  combinational grant to memory path
RSV_VALID  input  1  decoder reserves a destination register this cycle
RSV_ADDR  input  ADDR_WIDTH  register being reserved
RD1_ADDR  input  ADDR_WIDTH  source register 1 of instruction in decode
RD2_ADDR  input  ADDR_WIDTH  source register 2 of instruction in decode
STALL  output  1  combinational: a source register has a pending write
BUSY  output  NUM_REGS  bit i = register i has a pending write
WRITE  output  1  registered write strobe to register file
INADDRESS  output  ADDR_WIDTH  registered write address
IN  output  DATA_WIDTH  registered write data
ERR  output  1  sticky: counter overflow or unreserved write

Behaviour:
- Reset (async, RESET=1): WRITE=0, INADDRESS=0, IN=0, ERR=0.
  - All pending counters are 0, so BUSY=0 and STALL=0.
  - Priority pointer PRIO=ALU.
  - Outputs hold these values while RESET is high. Any in-flight request is dropped, and requesters must re-present it.
- Arbitration (combinational):
  - Only one REQ high: that requester is granted.
  - Both high: the PRIO side is granted. At most one GNT is high.
  - A transfer occurs at the posedge where REQ&GNT=1. The requester may drop or change REQ/ADDR/DATA after that edge.
  - A requester must not change ADDR/DATA while REQ=1 and GNT=0.
- Priority update: after every transfer, PRIO becomes the non-granted source, whether or not the other side was requesting. This gives strict alternation under contention.
- Write port:
  - At the transfer edge: WRITE<=1, INADDRESS<=granted ADDR, IN<=granted DATA.
  - With no transfer: WRITE<=0; INADDRESS/IN hold.
  - Latency: REQ accepted at edge N drives WRITE high during cycle N..N+1. The register file commits at edge N+1.
  - Throughput is one write per cycle.
- Scoreboard: each register has a pending counter of CNT_WIDTH bits.
  - +1 at an edge where RSV_VALID=1 for that address.
  - -1 at an edge where a transfer targets that address.
  - Reserve and transfer on the same address in the same edge: net 0.
  - Increment at max (3): counter saturates, ERR<=1.
  - Transfer to an address with counter 0: the write still proceeds, the counter stays 0, ERR<=1.
  - BUSY[i] = (counter i != 0), derived from registers.
  - The counter is cleared only when the write is issued (WRITE asserted), not when the register file commits.
- STALL = BUSY[RD1_ADDR] | BUSY[RD2_ADDR].
  - There is no bypass: a register reserved and written back in the same cycle still reads as not busy only if its net count is 0.
- ERR clears only on RESET.

Decomposition:
- Shared package holds:
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - Source-ID constants SRC_ALU=0, SRC_MEM=1 (the PRIO encoding).
- One natural sub-module, reg_pending_counter: a single saturating up/down counter with overflow/underflow flags. It is instantiated NUM_REGS times via generate.
- Arbiter, write-port register and ERR logic stay in the top module.

Test Plan:
- Reset: assert RESET mid-cycle -> WRITE=0, BUSY=8'h00, ERR=0, STALL=0 immediately, with no clock needed.
- Single ALU write: reserve R3 via RSV_VALID. Next cycle ALU_REQ with addr 3, data 8'h5A -> ALU_GNT=1 same cycle. Next cycle WRITE=1, INADDRESS=3, IN=8'h5A, BUSY[3]=0.
- Contention: after reset, reserve R1 and R2. ALU_REQ(R1,8'h11) and MEM_REQ(R2,8'h22) held high together -> ALU granted first, MEM next cycle. WRITE high for 2 consecutive cycles with INADDRESS 1 then 2.
- Hazard: reserve R4 with RD1_ADDR=4 -> STALL=1 until the edge after R4's grant, then 0. RD2_ADDR=5 (not reserved) alone -> STALL=0.
- Same-edge reserve+write: R6 count=1, then RSV_VALID(R6) coincides with a MEM transfer to R6 -> BUSY[6] stays 1, count 1. A second write then clears BUSY[6].
- Errors: reserve R0 four times -> BUSY[0]=1, ERR=1 after the 4th reserve. Separately after reset, an unreserved write to R7 -> WRITE pulses, ERR=1, BUSY[7]=0.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared defaults and source identifiers for the register-file write arbiter.
package reg_write_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int DEFAULT_CNT_WIDTH  = 2;

    // Writeback source identifiers; also the encoding of the priority pointer.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundle of writeback requests, reservations, hazard query and register-file write port.
interface reg_write_arbiter_if #(
    parameter int DATA_WIDTH = reg_write_arbiter_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_write_arbiter_pkg::DEFAULT_ADDR_WIDTH
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic                  ALU_REQ;
    logic [ADDR_WIDTH-1:0] ALU_ADDR;
    logic [DATA_WIDTH-1:0] ALU_DATA;
    logic                  ALU_GNT;
    logic                  MEM_REQ;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [DATA_WIDTH-1:0] MEM_DATA;
    logic                  MEM_GNT;
    logic                  RSV_VALID;
    logic [ADDR_WIDTH-1:0] RSV_ADDR;
    logic [ADDR_WIDTH-1:0] RD1_ADDR;
    logic [ADDR_WIDTH-1:0] RD2_ADDR;
    logic                  STALL;
    logic [NUM_REGS-1:0]   BUSY;
    logic                  WRITE;
    logic [ADDR_WIDTH-1:0] INADDRESS;
    logic [DATA_WIDTH-1:0] IN;
    logic                  ERR;

    // Pipeline stages side: requests and reservations out, grants and status in.
    modport master (
        output ALU_REQ, ALU_ADDR, ALU_DATA, MEM_REQ, MEM_ADDR, MEM_DATA,
        output RSV_VALID, RSV_ADDR, RD1_ADDR, RD2_ADDR,
        input  ALU_GNT, MEM_GNT, STALL, BUSY, WRITE, INADDRESS, IN, ERR
    );

    modport slave (
        input  ALU_REQ, ALU_ADDR, ALU_DATA, MEM_REQ, MEM_ADDR, MEM_DATA,
        input  RSV_VALID, RSV_ADDR, RD1_ADDR, RD2_ADDR,
        output ALU_GNT, MEM_GNT, STALL, BUSY, WRITE, INADDRESS, IN, ERR
    );

endinterface

// File: rtl/reg_pending_counter.sv
// Saturating up/down count of outstanding writes to one register.
module reg_pending_counter
    import reg_write_arbiter_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic CLK,
    input  logic RESET,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic overflow,
    output logic underflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;

    // Simultaneous inc and dec cancel, so neither flag can fire in that case.
    always_comb begin
        count_next = count_reg;
        overflow   = 1'b0;
        underflow  = 1'b0;
        if (inc && !dec) begin
            if (count_reg == CNT_MAX) overflow = 1'b1;
            else                      count_next = count_reg + CNT_ONE;
        end else if (dec && !inc) begin
            if (count_reg == '0) underflow = 1'b1;
            else                 count_next = count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) count_reg <= '0;
        else       count_reg <= count_next;
    end

    assign busy = (count_reg != '0);

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// per-register pending-write scoreboard for read-after-write stalls.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input logic               CLK,
    input logic               RESET,
    reg_write_arbiter_if.slave bus
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    src_t                  prio_reg;
    src_t                  prio_next;
    logic                  alu_gnt;
    logic                  mem_gnt;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] xfer_addr;
    logic [DATA_WIDTH-1:0] xfer_data;

    logic                  write_reg;
    logic [ADDR_WIDTH-1:0] inaddress_reg;
    logic [DATA_WIDTH-1:0] in_reg;
    logic                  err_reg;

    logic [NUM_REGS-1:0]   busy_vec;
    logic [NUM_REGS-1:0]   ovf_vec;
    logic [NUM_REGS-1:0]   unf_vec;

    // Grant and priority pointer; the pointer moves to the loser after every
    // transfer even when the other side was idle.
    always_comb begin
        alu_gnt   = bus.ALU_REQ && (!bus.MEM_REQ || prio_reg == SRC_ALU);
        mem_gnt   = bus.MEM_REQ && !alu_gnt;
        xfer      = alu_gnt || mem_gnt;
        xfer_addr = alu_gnt ? bus.ALU_ADDR : bus.MEM_ADDR;
        xfer_data = alu_gnt ? bus.ALU_DATA : bus.MEM_DATA;
        prio_next = prio_reg;
        if (alu_gnt)      prio_next = SRC_MEM;
        else if (mem_gnt) prio_next = SRC_ALU;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) prio_reg <= SRC_ALU;
        else       prio_reg <= prio_next;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            write_reg     <= 1'b0;
            inaddress_reg <= '0;
            in_reg        <= '0;
        end else begin
            write_reg <= xfer;
            if (xfer) begin
                inaddress_reg <= xfer_addr;
                in_reg        <= xfer_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pending
            reg_pending_counter #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_cnt (
                .CLK       (CLK),
                .RESET     (RESET),
                .inc       (bus.RSV_VALID && (bus.RSV_ADDR == ADDR_WIDTH'(gi))),
                .dec       (xfer && (xfer_addr == ADDR_WIDTH'(gi))),
                .busy      (busy_vec[gi]),
                .overflow  (ovf_vec[gi]),
                .underflow (unf_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) err_reg <= 1'b0;
        else       err_reg <= err_reg || (|ovf_vec) || (|unf_vec);
    end

    assign bus.ALU_GNT   = alu_gnt;
    assign bus.MEM_GNT   = mem_gnt;
    assign bus.BUSY      = busy_vec;
    assign bus.STALL     = busy_vec[bus.RD1_ADDR] || busy_vec[bus.RD2_ADDR];
    assign bus.WRITE     = write_reg;
    assign bus.INADDRESS = inaddress_reg;
    assign bus.IN        = in_reg;
    assign bus.ERR       = err_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and random stimulus for reg_write_arbiter, checked against a
// count-per-register / alternating-priority reference model.
module tb_reg_write_arbiter;

    logic CLK;
    logic RESET;

    reg_write_arbiter_if bus ();

    reg_write_arbiter dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned pass_cnt;
    int unsigned total_cnt;

    // Reference model state
    int m_cnt [8];
    int m_prio;            // 0 = ALU preferred, 1 = MEM preferred
    bit m_err;
    bit m_write;
    int m_addr;
    int m_data;
    bit last_alu_xfer;
    bit last_mem_xfer;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] m_busy();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    function automatic bit m_alu_gnt();
        return bus.ALU_REQ && (!bus.MEM_REQ || m_prio == 0);
    endfunction

    function automatic bit m_mem_gnt();
        return bus.MEM_REQ && (!bus.ALU_REQ || m_prio == 1);
    endfunction

    function automatic bit m_stall();
        logic [7:0] b;
        b = m_busy();
        return b[bus.RD1_ADDR] || b[bus.RD2_ADDR];
    endfunction

    task automatic check_comb();
        check("alu_gnt", bus.ALU_GNT, m_alu_gnt());
        check("mem_gnt", bus.MEM_GNT, m_mem_gnt());
        check("stall",   bus.STALL,   m_stall());
    endtask

    task automatic check_regs();
        check("write",     bus.WRITE,     m_write);
        check("inaddress", bus.INADDRESS, m_addr);
        check("in",        bus.IN,        m_data);
        check("busy",      bus.BUSY,      m_busy());
        check("err",       bus.ERR,       m_err);
        check_comb();
    endtask

    task automatic idle_inputs();
        bus.ALU_REQ = 0; bus.ALU_ADDR = 0; bus.ALU_DATA = 0;
        bus.MEM_REQ = 0; bus.MEM_ADDR = 0; bus.MEM_DATA = 0;
        bus.RSV_VALID = 0; bus.RSV_ADDR = 0;
        bus.RD1_ADDR = 0; bus.RD2_ADDR = 0;
    endtask

    task automatic settle();
        #1;
        check_comb();
    endtask

    // Called mid-cycle; the reset is asynchronous so no clock edge is needed.
    task automatic apply_reset();
        idle_inputs();
        RESET = 1;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_prio = 0; m_err = 0; m_write = 0; m_addr = 0; m_data = 0;
        #1;
        check_regs();
        RESET = 0;
        $display("reset");
    endtask

    task automatic tick();
        bit ag, mg, x;
        int a, d, n;
        int nc [8];
        ag = m_alu_gnt();
        mg = m_mem_gnt();
        x  = ag || mg;
        a  = ag ? int'(bus.ALU_ADDR) : int'(bus.MEM_ADDR);
        d  = ag ? int'(bus.ALU_DATA) : int'(bus.MEM_DATA);
        for (int i = 0; i < 8; i++) begin
            n = m_cnt[i];
            if (bus.RSV_VALID && bus.RSV_ADDR == i) n++;
            if (x && a == i) n--;
            if (n > 3) begin n = 3; m_err = 1; end
            if (n < 0) begin n = 0; m_err = 1; end
            nc[i] = n;
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) m_cnt[i] = nc[i];
        m_write = x;
        if (x) begin m_addr = a; m_data = d; end
        if (ag) m_prio = 1;
        else if (mg) m_prio = 0;
        last_alu_xfer = ag;
        last_mem_xfer = mg;
        if (x) $display("write %s addr=%0d data=%02h", ag ? "alu" : "mem", a, d);
        else   $display("cycle idle busy=%02h", m_busy());
        check_regs();
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        RESET = 0;
        idle_inputs();
        @(posedge CLK);
        #1;
        apply_reset();

        // Single ALU write to R3
        bus.RSV_VALID = 1; bus.RSV_ADDR = 3;
        settle(); tick();
        check("a_busy3_set", bus.BUSY[3], 1'b1);
        bus.RSV_VALID = 0;
        bus.ALU_REQ = 1; bus.ALU_ADDR = 3; bus.ALU_DATA = 8'h5A;
        settle();
        check("a_gnt", bus.ALU_GNT, 1'b1);
        tick();
        check("a_write", bus.WRITE, 1'b1);
        check("a_inaddr", bus.INADDRESS, 3);
        check("a_in", bus.IN, 8'h5A);
        check("a_busy3_clr", bus.BUSY[3], 1'b0);
        bus.ALU_REQ = 0;
        settle(); tick();

        // Contention: ALU first after reset, then MEM
        apply_reset();
        bus.RSV_VALID = 1; bus.RSV_ADDR = 1; settle(); tick();
        bus.RSV_ADDR = 2; settle(); tick();
        bus.RSV_VALID = 0;
        bus.ALU_REQ = 1; bus.ALU_ADDR = 1; bus.ALU_DATA = 8'h11;
        bus.MEM_REQ = 1; bus.MEM_ADDR = 2; bus.MEM_DATA = 8'h22;
        settle();
        check("b_alu_first", {bus.ALU_GNT, bus.MEM_GNT}, 2'b10);
        tick();
        check("b_addr1", bus.INADDRESS, 1);
        bus.ALU_REQ = 0;
        settle();
        check("b_mem_next", bus.MEM_GNT, 1'b1);
        tick();
        check("b_write2", bus.WRITE, 1'b1);
        check("b_addr2", bus.INADDRESS, 2);
        check("b_in2", bus.IN, 8'h22);
        bus.MEM_REQ = 0;
        settle(); tick();

        // Hazard on R4; R5 never reserved
        bus.RD1_ADDR = 4;
        bus.RSV_VALID = 1; bus.RSV_ADDR = 4; settle(); tick();
        bus.RSV_VALID = 0;
        check("c_stall_set", bus.STALL, 1'b1);
        bus.ALU_REQ = 1; bus.ALU_ADDR = 4; bus.ALU_DATA = 8'h44;
        settle();
        check("c_stall_hold", bus.STALL, 1'b1);
        tick();
        check("c_stall_clr", bus.STALL, 1'b0);
        bus.ALU_REQ = 0;
        bus.RD1_ADDR = 0; bus.RD2_ADDR = 5;
        settle();
        check("c_rd2_free", bus.STALL, 1'b0);
        tick();

        // Same-edge reserve and write on R6
        bus.RSV_VALID = 1; bus.RSV_ADDR = 6; settle(); tick();
        bus.MEM_REQ = 1; bus.MEM_ADDR = 6; bus.MEM_DATA = 8'h66;
        settle(); tick();
        check("d_busy6_held", bus.BUSY[6], 1'b1);
        bus.RSV_VALID = 0;
        bus.MEM_DATA = 8'h67;
        settle(); tick();
        check("d_busy6_clr", bus.BUSY[6], 1'b0);
        bus.MEM_REQ = 0;
        settle(); tick();

        // Overflow on R0, then async reset clears it
        apply_reset();
        bus.RSV_VALID = 1; bus.RSV_ADDR = 0;
        for (int k = 0; k < 4; k++) begin settle(); tick(); end
        check("e_err_ovf", bus.ERR, 1'b1);
        check("e_busy0", bus.BUSY[0], 1'b1);
        apply_reset();
        check("e_rst_busy", bus.BUSY, 8'h00);
        check("e_rst_err", bus.ERR, 1'b0);

        // Unreserved write to R7
        bus.ALU_REQ = 1; bus.ALU_ADDR = 7; bus.ALU_DATA = 8'h77;
        settle(); tick();
        check("e_unres_write", bus.WRITE, 1'b1);
        check("e_unres_err", bus.ERR, 1'b1);
        check("e_unres_busy7", bus.BUSY[7], 1'b0);
        bus.ALU_REQ = 0;
        settle(); tick();

        // Random traffic with periodic resets so ERR stays informative
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 59) apply_reset();
            if (bus.ALU_REQ && last_alu_xfer) bus.ALU_REQ = 0;
            if (bus.MEM_REQ && last_mem_xfer) bus.MEM_REQ = 0;
            if (!bus.ALU_REQ && $urandom_range(0, 1) == 1) begin
                bus.ALU_REQ  = 1;
                bus.ALU_ADDR = 3'($urandom_range(0, 7));
                bus.ALU_DATA = 8'($urandom_range(0, 255));
            end
            if (!bus.MEM_REQ && $urandom_range(0, 1) == 1) begin
                bus.MEM_REQ  = 1;
                bus.MEM_ADDR = 3'($urandom_range(0, 7));
                bus.MEM_DATA = 8'($urandom_range(0, 255));
            end
            bus.RSV_VALID = ($urandom_range(0, 9) < 6);
            bus.RSV_ADDR  = 3'($urandom_range(0, 7));
            bus.RD1_ADDR  = 3'($urandom_range(0, 7));
            bus.RD2_ADDR  = 3'($urandom_range(0, 7));
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
